fec_encoder: RTL and testbench
==============================

FEC_ENCODER -- requirements
Module: fec_encoder

Interface
REQ-001 Parameter BLOCK_LEN, default 96: information bits per block; SHALL be >= 7; output block is 2*BLOCK_LEN bits.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 valid_in  input  1  upstream asserts that fec_in carries a valid bit.
REQ-005 fec_in  input  1  serial information bit, first bit of block first.
REQ-006 ready_in  input  1  downstream is ready to accept fec_out.
REQ-007 ready_out  output  1  block can accept an input bit this cycle.
REQ-008 valid_out  output  1  fec_out carries a valid coded bit.
REQ-009 fec_out  output  1  serial coded bit, MSB of the coded block first.

Function
REQ-010 The block SHALL implement a rate-1/2, K=7, tail-biting convolutional encoder with G1=171 octal (X) and G2=133 octal (Y), per IEEE 802.16 OFDM PHY.
REQ-011 Input transfer: a bit SHALL be accepted on a rising edge where valid_in=1 and ready_out=1; the bit is stored in the input buffer at the index given by the input counter (0..BLOCK_LEN-1), and the counter increments.
REQ-012 If valid_in deasserts mid-block, the buffer and counter SHALL hold; accumulation resumes when valid_in returns.
REQ-013 For received bits d0..d(N-1), N=BLOCK_LEN, with indices taken mod N: Xk = dk^d(k-1)^d(k-2)^d(k-3)^d(k-6); Yk = dk^d(k-2)^d(k-3)^d(k-5)^d(k-6). Equivalently, the encoder state is preloaded with the last six bits of the block.
REQ-014 The coded block SHALL be ordered X0,Y0,X1,Y1,...,X(N-1),Y(N-1) and held in the internal 2N-bit register fec_out_reg, with X0 at bit 2N-1 (MSB).
REQ-015 Load: fec_out_reg SHALL be loaded with the full coded block on the edge after the N-th bit is accepted, provided the output stage is idle or is completing its final transfer on that edge. Otherwise the load SHALL wait until that condition holds.
REQ-016 Loading SHALL free the input buffer; the input counter SHALL return to 0.
REQ-017 ready_out SHALL be 1 while the input buffer holds fewer than N bits, and 0 while a complete block awaits loading.
REQ-018 Output: from the cycle after a load, valid_out SHALL be 1 and fec_out SHALL equal the current MSB of the output shift register. Each edge with valid_out=1 and ready_in=1 SHALL advance one bit.
REQ-019 While ready_in=0, fec_out and valid_out SHALL hold.
REQ-020 After 2N output transfers, valid_out SHALL drop to 0, unless a pending block loads on that same edge, in which case output SHALL continue with no gap.
REQ-021 fec_out_reg SHALL retain the last loaded coded block (not shifted away) until the next load; a separate shift copy SHALL drive fec_out.
REQ-022 Throughput: input collection of block n+1 SHALL overlap with output of block n (double buffering). Sustained input rate is therefore limited to N bits per 2N cycles by ready_out.
REQ-023 Latency: the first coded bit SHALL appear on fec_out 2 cycles after acceptance of the last input bit, when the output stage is idle.

Reset
REQ-024 While reset=0: input buffer, input counter, output shift register, output counter and fec_out_reg SHALL be 0; valid_out=0, fec_out=0, ready_out=1.
REQ-025 Assertion of reset mid-block or mid-output SHALL discard all partial data. After release, the first accepted bit SHALL be d0 of a new block.

Verification
REQ-026 Feed 96 bits 558AC4A53A1724E163AC2BF9 (MSB first) with ready_in=1 -> fec_out_reg = 2833E48D392026D5B6DC5E4AF47ADD29494B6C89151348CA, and 192 serial bits on fec_out matching it MSB first, beginning 2 cycles after the last input.
REQ-027 Feed the same block 4 times back-to-back, obeying ready_out -> each of 4 coded blocks matches REQ-026; valid_out is continuous between blocks 2..4; ready_out goes low while a full block waits.
REQ-028 All-zero 96-bit block -> 192 zero coded bits. Single 1 at d0, rest 0 -> coded bits 0,1 = 1,1 and the six tail-biting bits of REQ-013 positioned correctly.
REQ-029 Toggle valid_in low for 10 cycles mid-block, and ready_in low for 10 cycles mid-output -> coded result still equals REQ-026; fec_out holds during stalls.
REQ-030 Pull reset low after 50 input bits, release, then feed the full REQ-026 block -> output equals REQ-026 with no residue from the aborted block.

Source files
------------

// File: rtl/fec_encoder_if.sv
// -----------------------------------------------------------------------------
// fec_encoder_if
//   Serial handshake bundle for fec_encoder.
//
//   Handshake rule (both directions): a bit moves on a rising clk edge where the
//   sender's valid and the receiver's ready are both 1. The sender holds its
//   data and valid steady until that edge. Ready may change freely.
//
//   Signals
//     valid_in  : upstream -> encoder, fec_in carries a valid bit
//     fec_in    : upstream -> encoder, serial information bit (d0 first)
//     ready_out : encoder -> upstream, encoder can take a bit this cycle
//     valid_out : encoder -> downstream, fec_out carries a valid coded bit
//     fec_out   : encoder -> downstream, serial coded bit (MSB of block first)
//     ready_in  : downstream -> encoder, downstream takes fec_out this cycle
//
//   modport slave  : the encoder side
//   modport master : the environment (upstream source and downstream sink)
// -----------------------------------------------------------------------------
interface fec_encoder_if;
   logic valid_in;
   logic fec_in;
   logic ready_out;
   logic valid_out;
   logic fec_out;
   logic ready_in;

   modport slave (
      input  valid_in,
      input  fec_in,
      input  ready_in,
      output ready_out,
      output valid_out,
      output fec_out
   );

   modport master (
      output valid_in,
      output fec_in,
      output ready_in,
      input  ready_out,
      input  valid_out,
      input  fec_out
   );
endinterface

// File: rtl/fec_encoder.sv
// -----------------------------------------------------------------------------
// fec_encoder
//   Rate-1/2, K=7 tail-biting convolutional encoder (G1=171o -> X,
//   G2=133o -> Y). A block of BLOCK_LEN serial bits is collected into an input
//   buffer, encoded in one step into a 2*BLOCK_LEN-bit coded block ordered
//   X0,Y0,X1,Y1,... (X0 at the MSB) and shifted out MSB first. Collection of
//   the next block overlaps with the output of the current one.
//
//   Ports
//     clk           : clock, rising edge active
//     reset         : asynchronous reset, active low
//     fec_if        : serial in/out handshake bundle (slave side)
//     fec_out_reg_o : last loaded coded block (debug view of fec_out_reg)
//     out_state_o   : output stage state (0 = idle, 1 = busy), debug view
// -----------------------------------------------------------------------------
module fec_encoder #(
   parameter int BLOCK_LEN = 96
) (
   input  logic                   clk,
   input  logic                   reset,
   fec_encoder_if.slave           fec_if,
   output logic [2*BLOCK_LEN-1:0] fec_out_reg_o,
   output logic [0:0]             out_state_o
);

   localparam int N  = BLOCK_LEN;
   localparam int W  = 2 * BLOCK_LEN;
   localparam int CW = $clog2(N + 1);
   localparam int OW = $clog2(W);

   localparam logic [CW-1:0] CNT_FULL = CW'(N);
   localparam logic [OW-1:0] OUT_LAST = OW'(W - 1);

   typedef enum logic [0:0] {
      OUT_IDLE = 1'b0,
      OUT_BUSY = 1'b1
   } out_state_t;

   out_state_t    out_state_q;
   logic [N-1:0]  in_buf_q;       // in_buf_q[k] holds dk
   logic [CW-1:0] in_cnt_q;       // bits collected, N means block complete
   logic [W-1:0]  fec_out_reg_q;  // retained copy of the coded block
   logic [W-1:0]  shift_q;        // working copy shifted towards fec_out
   logic [OW-1:0] out_cnt_q;      // index of the bit currently on fec_out
   logic [W-1:0]  coded_d;

   logic accept;
   logic xfer;
   logic last_xfer;
   logic block_full;
   logic load;

   // Tail-biting encode: indices wrap modulo N, so the encoder state at k=0
   // is the last six bits of the block. All indices are elaboration constants.
   for (genvar k = 0; k < N; k++) begin : g_enc
      localparam int I1 = (k + N - 1) % N;
      localparam int I2 = (k + N - 2) % N;
      localparam int I3 = (k + N - 3) % N;
      localparam int I5 = (k + N - 5) % N;
      localparam int I6 = (k + N - 6) % N;
      assign coded_d[W-1-2*k] = in_buf_q[k] ^ in_buf_q[I1] ^ in_buf_q[I2]
                              ^ in_buf_q[I3] ^ in_buf_q[I6];
      assign coded_d[W-2-2*k] = in_buf_q[k] ^ in_buf_q[I2] ^ in_buf_q[I3]
                              ^ in_buf_q[I5] ^ in_buf_q[I6];
   end

   assign block_full = (in_cnt_q == CNT_FULL);
   assign accept     = fec_if.valid_in && !block_full;
   assign xfer       = (out_state_q == OUT_BUSY) && fec_if.ready_in;
   assign last_xfer  = xfer && (out_cnt_q == OUT_LAST);
   // A complete block moves to the output stage when the stage is idle or is
   // handing over its final bit on this edge, giving gap-free output.
   assign load       = block_full && ((out_state_q == OUT_IDLE) || last_xfer);

   assign fec_if.ready_out = !block_full;
   assign fec_if.valid_out = (out_state_q == OUT_BUSY);
   assign fec_if.fec_out   = shift_q[W-1];
   assign fec_out_reg_o    = fec_out_reg_q;
   assign out_state_o      = out_state_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_state_q   <= OUT_IDLE;
         in_buf_q      <= '0;
         in_cnt_q      <= '0;
         fec_out_reg_q <= '0;
         shift_q       <= '0;
         out_cnt_q     <= '0;
      end else begin
         // Input side. accept and load are exclusive: load needs a full
         // buffer, accept needs a non-full one.
         if (load) begin
            in_buf_q <= '0;
            in_cnt_q <= '0;
         end else if (accept) begin
            in_buf_q[in_cnt_q] <= fec_if.fec_in;
            in_cnt_q           <= in_cnt_q + CW'(1);
         end

         // Output side.
         if (load) begin
            fec_out_reg_q <= coded_d;
            shift_q       <= coded_d;
            out_cnt_q     <= '0;
            out_state_q   <= OUT_BUSY;
         end else if (xfer) begin
            shift_q <= {shift_q[W-2:0], 1'b0};
            if (out_cnt_q == OUT_LAST) begin
               out_cnt_q   <= '0;
               out_state_q <= OUT_IDLE;
            end else begin
               out_cnt_q <= out_cnt_q + OW'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_fec_encoder.sv
// -----------------------------------------------------------------------------
// tb_fec_encoder
//   Directed bench for fec_encoder. A reference encoder written as a K=7 shift
//   register with octal generator masks predicts every coded bit; a monitor
//   compares each output transfer and each stall cycle against it.
// -----------------------------------------------------------------------------
module tb_fec_encoder;

   localparam int N = 96;
   localparam int W = 2 * N;

   localparam logic [N-1:0] BLK_A   = 96'h558AC4A53A1724E163AC2BF9;
   localparam logic [W-1:0] CODED_A =
      192'h2833E48D392026D5B6DC5E4AF47ADD29494B6C89151348CA;
   localparam logic [N-1:0] BLK_IMP = {1'b1, 95'd0};
   localparam logic [W-1:0] CODED_IMP = {16'hEF1C, 176'd0};

   logic clk;
   logic rst_n;
   logic [W-1:0] fec_out_reg;
   logic [0:0]   out_state;

   fec_encoder_if bus ();

   fec_encoder #(.BLOCK_LEN(N)) dut (
      .clk           (clk),
      .reset         (rst_n),
      .fec_if        (bus),
      .fec_out_reg_o (fec_out_reg),
      .out_state_o   (out_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard state ----------------
   int errors = 0;
   int checks = 0;
   logic         exp_q[$];
   logic [W-1:0] exp_blk_q[$];
   int bit_idx = 0;
   int drops = 0;
   int rdy_low = 0;
   logic prev_valid = 1'b0;
   logic prev_rdy = 1'b0;
   logic prev_fec = 1'b0;

   task automatic chk(input string name, input logic [W-1:0] act,
                      input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference encoder: state preloaded with the last six bits, then each
   // information bit shifted in; X/Y are parities of the generator taps.
   function automatic logic [W-1:0] model_encode(input logic [N-1:0] blk);
      logic [5:0]   s;
      logic [6:0]   f;
      logic [W-1:0] r;
      logic [6:0]   g1;
      logic [6:0]   g2;
      g1 = 7'o171;
      g2 = 7'o133;
      r  = '0;
      s  = {blk[0], blk[1], blk[2], blk[3], blk[4], blk[5]};
      for (int k = 0; k < N; k++) begin
         f = {blk[N-1-k], s};
         r[W-1-2*k] = ^(f & g1);
         r[W-2-2*k] = ^(f & g2);
         s = f[6:1];
      end
      return r;
   endfunction

   task automatic push_block(input logic [N-1:0] blk);
      logic [W-1:0] c;
      c = model_encode(blk);
      exp_blk_q.push_back(c);
      for (int i = W - 1; i >= 0; i--) exp_q.push_back(c[i]);
   endtask

   // ---------------- monitor / compare ----------------
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_valid = 1'b0;
         prev_rdy   = 1'b0;
         prev_fec   = 1'b0;
         bit_idx    = 0;
      end else begin
         if (prev_valid && !prev_rdy)
            chk("stall_hold", {{(W-2){1'b0}}, bus.valid_out, bus.fec_out},
                {{(W-2){1'b0}}, 1'b1, prev_fec});
         if (bus.valid_out && bus.ready_in) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_out", {{(W-1){1'b0}}, bus.fec_out},
                   {{(W-1){1'b0}}, ~bus.fec_out});
            end else begin
               logic e;
               e = exp_q.pop_front();
               chk($sformatf("fec_out[%0d]", bit_idx),
                   {{(W-1){1'b0}}, bus.fec_out}, {{(W-1){1'b0}}, e});
               if (bit_idx == 0 && exp_blk_q.size() != 0)
                  chk("fec_out_reg", fec_out_reg, exp_blk_q.pop_front());
               bit_idx = (bit_idx + 1) % W;
            end
         end
         if (prev_valid && !bus.valid_out) drops++;
         if (!bus.ready_out) rdy_low++;
         prev_valid = bus.valid_out;
         prev_rdy   = bus.ready_in;
         prev_fec   = bus.fec_out;
      end
   end

   // ---------------- driver tasks ----------------
   // Called at posedge+1; returns at posedge+1 of the edge that took the last bit.
   task automatic send_bits(input logic [N-1:0] blk, input int nbits,
                            input int stall_at, input int stall_len);
      int   k = 0;
      int   guard = 0;
      logic acc;
      logic stalled = 1'b0;
      if (nbits == N) push_block(blk);
      while (k < nbits) begin
         if (k == stall_at && !stalled) begin
            stalled = 1'b1;
            bus.valid_in = 1'b0;
            repeat (stall_len) begin
               @(posedge clk);
               #1;
            end
         end
         bus.valid_in = 1'b1;
         bus.fec_in   = blk[N-1-k];
         acc = bus.ready_out;
         @(posedge clk);
         #1;
         if (acc) begin
            k++;
         end else begin
            guard++;
            if (guard > 2000) begin
               chk("input_timeout", W'(k), W'(nbits));
               break;
            end
         end
      end
      bus.valid_in = 1'b0;
      bus.fec_in   = 1'b0;
   endtask

   task automatic wait_drain();
      int guard = 0;
      while ((exp_q.size() != 0 || bus.valid_out) && guard < 3000) begin
         @(posedge clk);
         #1;
         guard++;
      end
      if (guard >= 3000) chk("drain_timeout", W'(exp_q.size()), '0);
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_state(input string tag);
      chk({tag, "_ready_out"}, W'(bus.ready_out), W'(1));
      chk({tag, "_valid_out"}, W'(bus.valid_out), '0);
      chk({tag, "_fec_out"}, W'(bus.fec_out), '0);
      chk({tag, "_fec_out_reg"}, fec_out_reg, '0);
      chk({tag, "_state"}, W'(out_state), '0);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int d0;
      int r0;
      bus.valid_in = 1'b0;
      bus.fec_in   = 1'b0;
      bus.ready_in = 1'b1;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_state("reset");
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Pin the reference model with hand-derived vectors.
      chk("model_blkA", model_encode(BLK_A), CODED_A);
      chk("model_zero", model_encode('0), '0);
      chk("model_impulse", model_encode(BLK_IMP), CODED_IMP);

      // Single block, latency and retention.
      send_bits(BLK_A, N, -1, 0);
      chk("full_ready_out", W'(bus.ready_out), '0);
      chk("latency_not_yet", W'(bus.valid_out), '0);
      @(posedge clk);
      #1;
      chk("latency_valid", W'(bus.valid_out), W'(1));
      chk("after_load_ready", W'(bus.ready_out), W'(1));
      wait_drain();
      chk("retained_reg", fec_out_reg, CODED_A);

      // All-zero and impulse blocks.
      send_bits('0, N, -1, 0);
      wait_drain();
      send_bits(BLK_IMP, N, -1, 0);
      wait_drain();
      chk("impulse_reg", fec_out_reg, CODED_IMP);

      // Four blocks back to back.
      d0 = drops;
      r0 = rdy_low;
      repeat (4) send_bits(BLK_A, N, -1, 0);
      wait_drain();
      chk("b2b_valid_drops", W'(drops - d0), W'(1));
      chk("b2b_ready_low", W'(rdy_low - r0 > 50), W'(1));

      // Input stall mid-block, output stall mid-stream.
      send_bits(BLK_A, N, 40, 10);
      repeat (60) begin
         @(posedge clk);
         #1;
      end
      bus.ready_in = 1'b0;
      repeat (10) begin
         @(posedge clk);
         #1;
      end
      bus.ready_in = 1'b1;
      wait_drain();
      chk("stall_reg", fec_out_reg, CODED_A);

      // Reset after a partial block.
      send_bits(BLK_A, 50, -1, 0);
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_reset_state("midreset");
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      send_bits(BLK_A, N, -1, 0);
      wait_drain();
      chk("post_reset_reg", fec_out_reg, CODED_A);
      chk("queue_empty", W'(exp_q.size()), '0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
